// File: rtl/muldiv_unit.sv
// ============================================================================
// Module  : muldiv_unit
// Brief   : Multi-cycle unsigned multiply (shift-add) / divide (restoring) unit
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_unit #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start_in,
    input  logic [1:0]   op_in,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    output logic         busy_out,
    output logic         done_out,
    output logic [W-1:0] result_out
);

    localparam int                 c_cnt_w = (W > 1) ? $clog2(W) : 1;
    localparam logic [1:0]         c_idle  = 2'd0;
    localparam logic [1:0]         c_calc  = 2'd1;
    localparam logic [1:0]         c_done  = 2'd2;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(W - 1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_cnt_w-1:0] r_count;
    logic [1:0]         r_op;
    logic [W-1:0]       r_opnd;     // multiplicand for MUL, divisor for DIV
    logic [W:0]         r_hi;       // product high half / partial remainder
    logic [W-1:0]       r_lo;       // multiplier bits / dividend-then-quotient
    logic [W-1:0]       r_result;

    logic               w_accept;
    logic               w_last;
    logic [W:0]         w_mul_sum;
    logic [W:0]         w_shift;
    logic [W+1:0]       w_diff;
    logic               w_borrow;
    logic [W:0]         w_hi_nxt;
    logic [W-1:0]       w_lo_nxt;
    logic [W-1:0]       w_result_nxt;

    assign w_accept = start_in && ((r_state == c_idle) || (r_state == c_done));
    assign w_last   = (r_count == c_last);

    // Shift-add step: add the multiplicand when the current multiplier bit is
    // set, then shift the whole {hi, lo} product right by one.
    assign w_mul_sum = r_hi + (r_lo[0] ? {1'b0, r_opnd} : {(W+1){1'b0}});

    // Restoring step: the extra top bit of w_diff captures the borrow, so a
    // zero divisor never borrows and yields all-ones quotient, remainder = a.
    assign w_shift  = {r_hi[W-1:0], r_lo[W-1]};
    assign w_diff   = {1'b0, w_shift} - {2'b00, r_opnd};
    assign w_borrow = w_diff[W+1];

    always_comb begin
        w_hi_nxt     = r_hi;
        w_lo_nxt     = r_lo;
        w_result_nxt = r_result;
        if (r_op[1]) begin
            w_hi_nxt = w_borrow ? w_shift : w_diff[W:0];
            w_lo_nxt = {r_lo[W-2:0], ~w_borrow};
        end else begin
            w_hi_nxt = {1'b0, w_mul_sum[W:1]};
            w_lo_nxt = {w_mul_sum[0], r_lo[W-1:1]};
        end
        case (r_op)
            2'b00:   w_result_nxt = w_lo_nxt;
            2'b01:   w_result_nxt = w_hi_nxt[W-1:0];
            2'b10:   w_result_nxt = w_lo_nxt;
            default: w_result_nxt = w_hi_nxt[W-1:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle:  if (start_in) w_state_nxt = c_calc;
            c_calc:  if (w_last)   w_state_nxt = c_done;
            c_done:  w_state_nxt = start_in ? c_calc : c_idle;
            default: w_state_nxt = c_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count  <= '0;
            r_op     <= '0;
            r_opnd   <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_count <= '0;
            r_op    <= op_in;
            r_opnd  <= op_in[1] ? b_in : a_in;
            r_hi    <= '0;
            r_lo    <= op_in[1] ? a_in : b_in;
        end else if (r_state == c_calc) begin
            r_count <= r_count + c_cnt_w'(1);
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
            if (w_last) begin
                r_result <= w_result_nxt;
            end
        end
    end

    assign busy_out   = (r_state == c_calc);
    assign done_out   = (r_state == c_done);
    assign result_out = r_result;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// Module  : tb_muldiv_unit
// Brief   : Self-checking bench for muldiv_unit against an arithmetic model
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_unit;

    localparam int W = 16;

    logic         clk;
    logic         reset;
    logic         start_in;
    logic [1:0]   op_in;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         busy_out;
    logic         done_out;
    logic [W-1:0] result_out;

    int n_checks = 0;
    int n_errors = 0;

    muldiv_unit #(.W(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_in   (start_in),
        .op_in      (op_in),
        .a_in       (a_in),
        .b_in       (b_in),
        .busy_out   (busy_out),
        .done_out   (done_out),
        .result_out (result_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Plain arithmetic reference.
    function automatic logic [W-1:0] ref_model(input logic [1:0] op,
                                               input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        longint unsigned p;
        p = longint'(a) * longint'(b);
        case (op)
            2'b00:   return p[W-1:0];
            2'b01:   return p[2*W-1:W];
            2'b10:   return (b == 0) ? {W{1'b1}} : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one op (also accepted from the DONE cycle) and returns while in
    // its DONE cycle. A non-zero glitch_at pulses start_in in that CALC cycle.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int glitch_at);
        logic [W-1:0] exp;
        logic [W-1:0] prev;
        int           lat;
        int           busy_cnt;
        bit           changed;
        exp      = ref_model(op, a, b);
        prev     = result_out;
        changed  = 1'b0;
        start_in = 1'b1;
        op_in    = op;
        a_in     = a;
        b_in     = b;
        tick();
        lat      = 1;
        busy_cnt = 0;
        while (!done_out && lat < 40) begin
            if (busy_out) busy_cnt++;
            if (result_out !== prev) changed = 1'b1;
            start_in = (lat == glitch_at);
            op_in    = 2'($urandom);
            a_in     = W'($urandom);
            b_in     = W'($urandom);
            tick();
            lat++;
        end
        start_in = 1'b0;
        check("latency", lat, 17);
        check("busy_cycles", busy_cnt, 16);
        check("result_held_in_calc", {31'd0, changed}, 32'd0);
        check("busy_in_done", busy_out, 0);
        check($sformatf("result op%0d a=%0h b=%0h", op, a, b), result_out, exp);
    endtask

    task automatic idle_check();
        logic [W-1:0] prev;
        prev     = result_out;
        start_in = 1'b0;
        tick();
        check("done_single_pulse", done_out, 0);
        check("idle_busy", busy_out, 0);
        check("idle_hold", result_out, prev);
    endtask

    initial begin
        int done_seen;
        reset    = 1'b1;
        start_in = 1'b0;
        op_in    = '0;
        a_in     = '0;
        b_in     = '0;
        tick();
        tick();
        check("rst_busy", busy_out, 0);
        check("rst_done", done_out, 0);
        check("rst_result", result_out, 0);
        reset = 1'b0;
        tick();
        check("idle_after_rst", busy_out, 0);

        run_op(2'b00, 16'h1234, 16'h0010, 0);
        check("mullo_const", result_out, 16'h2340);
        idle_check();
        run_op(2'b01, 16'hFFFF, 16'hFFFF, 0);
        check("mulhi_const", result_out, 16'hFFFE);
        run_op(2'b00, 16'hFFFF, 16'hFFFF, 0);
        check("mullo_b2b_const", result_out, 16'h0001);
        idle_check();
        run_op(2'b10, 16'd1000, 16'd7, 0);
        check("divq_const", result_out, 16'h008E);
        run_op(2'b11, 16'd1000, 16'd7, 0);
        check("divr_const", result_out, 16'h0006);
        run_op(2'b10, 16'd5, 16'd9, 0);
        run_op(2'b11, 16'd5, 16'd9, 0);
        idle_check();
        run_op(2'b10, 16'h5A5A, 16'h0000, 0);
        check("divq_zero_const", result_out, 16'hFFFF);
        run_op(2'b11, 16'h5A5A, 16'h0000, 0);
        check("divr_zero_const", result_out, 16'h5A5A);
        idle_check();
        run_op(2'b00, 16'h00FF, 16'h0101, 5);
        idle_check();

        // Abort in CALC cycle 8.
        start_in = 1'b1;
        op_in    = 2'b01;
        a_in     = 16'hBEEF;
        b_in     = 16'h1234;
        tick();
        start_in = 1'b0;
        repeat (7) tick();
        check("pre_abort_busy", busy_out, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", busy_out, 0);
        check("abort_done", done_out, 0);
        check("abort_result", result_out, 0);
        done_seen = 0;
        repeat (30) begin
            tick();
            if (done_out) done_seen++;
        end
        check("abort_no_done", done_seen, 0);

        // Reset wins over a simultaneous start.
        reset    = 1'b1;
        start_in = 1'b1;
        tick();
        reset    = 1'b0;
        start_in = 1'b0;
        check("rst_start_busy", busy_out, 0);
        tick();
        check("rst_start_dropped", busy_out, 0);

        for (int i = 0; i < 60; i++) begin
            logic [1:0]   op;
            logic [W-1:0] a;
            logic [W-1:0] b;
            op = 2'($urandom);
            a  = W'($urandom);
            b  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            if ($urandom_range(0, 3) == 0) b = W'($urandom_range(1, 15));
            run_op(op, a, b, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : 0);
            if ($urandom_range(0, 1) == 0) idle_check();
        end
        idle_check();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
